// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed D priority).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_I    = 2'd1,
        R_D    = 2'd2,
        R_DOFF = 2'd3
    } rsp_e;

    localparam logic [15:0] DUMMY_DATA = 16'hDEAD;

    // A byte address is in-region when every bit above the word index is zero.
    function automatic logic in_region(input logic [31:0] addr, input int abits);
        return (addr >> (abits + 1)) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Pure grant logic: resolves I vs in-region D contention for the memory port.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise D wins.
module mem_arb_select (
    input  logic i_req,
    input  logic d_req,
    input  logic d_in_region,
    input  logic last_d,
    output logic i_gnt,
    output logic d_gnt
);
    logic contend;

    always_comb begin
        contend = i_req & d_req & d_in_region;
        i_gnt   = i_req;
        d_gnt   = d_req;
        if (contend) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            d_gnt = ~last_d;
            i_gnt = last_d;
`else
            i_gnt = 1'b0;
`endif
        end
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = last_d;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (I) and load/store (D),
// returns responses one cycle after grant and counts fetch stall cycles.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DBITS = 16,
    parameter int ABITS = 12
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_REQ,
    input  logic [DBITS-1:0] I_ADDR,
    output logic             I_GNT,
    output logic             I_VALID,
    output logic [DBITS-1:0] I_DATA,
    input  logic             D_REQ,
    input  logic             D_WE,
    input  logic [DBITS-1:0] D_ADDR,
    input  logic [DBITS-1:0] D_DIN,
    output logic             D_GNT,
    output logic             D_VALID,
    output logic [DBITS-1:0] D_DATA,
    output logic [ABITS-1:0] M_ADDR,
    output logic [DBITS-1:0] M_DIN,
    output logic             M_WE,
    input  logic [DBITS-1:0] M_DOUT,
    output logic [15:0]      I_STALL_CNT
);
    logic             d_in, sel_i, sel_d, i_gnt, d_gnt;
    logic [ABITS-1:0] m_addr_d, m_addr_q;
    rsp_e             i_rsp_d, i_rsp_q, d_rsp_d, d_rsp_q;
    logic             d_st_d, d_st_q, last_d_d, last_d_q;
    logic [15:0]      cnt_d, cnt_q;

    logic unused_bits;
    assign unused_bits = ^{I_ADDR[DBITS-1:ABITS+1], I_ADDR[0], D_ADDR[0]};

    assign d_in = in_region(32'(D_ADDR), ABITS);

    mem_arb_select u_sel (
        .i_req       (I_REQ),
        .d_req       (D_REQ),
        .d_in_region (d_in),
        .last_d      (last_d_q),
        .i_gnt       (sel_i),
        .d_gnt       (sel_d)
    );

    always_comb begin
        i_gnt    = sel_i & ~RESET;
        d_gnt    = sel_d & ~RESET;
        m_addr_d = m_addr_q;
        if (d_gnt && d_in)
            m_addr_d = D_ADDR[ABITS:1];
        else if (i_gnt)
            m_addr_d = I_ADDR[ABITS:1];
        i_rsp_d  = i_gnt ? R_I : R_IDLE;
        d_rsp_d  = !d_gnt ? R_IDLE : (d_in ? R_D : R_DOFF);
        d_st_d   = D_WE;
        last_d_d = last_d_q;
        if (d_gnt && d_in)
            last_d_d = 1'b1;
        else if (i_gnt)
            last_d_d = 1'b0;
        cnt_d = cnt_q;
        if (I_REQ && !i_gnt && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    // Response state is split: the I flag and the D state advance independently
    // because an off-region D response can share a cycle with an I response.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_addr_q <= '0;
            i_rsp_q  <= R_IDLE;
            d_rsp_q  <= R_IDLE;
            d_st_q   <= 1'b0;
            last_d_q <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            m_addr_q <= m_addr_d;
            i_rsp_q  <= i_rsp_d;
            d_rsp_q  <= d_rsp_d;
            d_st_q   <= d_st_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        D_DATA = '0;
        case (d_rsp_q)
            R_D:     D_DATA = d_st_q ? '0 : M_DOUT;
            R_DOFF:  D_DATA = DBITS'(DUMMY_DATA);
            default: D_DATA = '0;
        endcase
    end

    assign I_GNT       = i_gnt;
    assign D_GNT       = d_gnt;
    assign M_ADDR      = m_addr_d;
    assign M_DIN       = D_DIN;
    assign M_WE        = d_gnt & D_WE & d_in;
    assign I_VALID     = (i_rsp_q == R_I);
    assign I_DATA      = M_DOUT;
    assign D_VALID     = (d_rsp_q != R_IDLE);
    assign I_STALL_CNT = cnt_q;

endmodule
